prog_loader_ctrl: RTL and testbench

Synthesizable host-side controller that drives the processor's program-load and register-readback ports, replacing the bench-only stimulus. It takes a byte stream and assembles big-endian 32-bit instruction words. It writes them into instruction memory over `addr`/`wr`/`wdata`, holds `working` high for a fixed run window, then scans `rID` across the register file and streams each `rdata` value out. It sits between an external link (UART/FIFO) and the `processor` top.

---
 rtl/prog_loader_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_prog_loader_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader_ctrl.sv
// Host-side program loader: assembles big-endian words from a byte stream, writes them
// to instruction memory, runs the processor for a fixed window, then streams out registers.
module prog_loader_ctrl #(
  parameter int unsigned WORDS      = 32,
  parameter int unsigned RUN_CYCLES = 155,
  parameter int unsigned NREGS      = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic [31:0] addr,
  output logic        wr,
  output logic [31:0] wdata,
  output logic        working,
  output logic [3:0]  rID,
  input  logic [31:0] rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DWAIT = 3'd3;
  localparam logic [2:0] S_DOUT  = 3'd4;

  localparam int unsigned   RW       = $clog2(RUN_CYCLES + 1);
  localparam logic [8:0]    MAXW     = 9'(WORDS);
  localparam logic [3:0]    LAST_REG = 4'(NREGS - 1);
  localparam logic [RW-1:0] RUN_LAST = RW'(RUN_CYCLES - 1);

  logic [2:0]    state_q, state_d;
  logic [8:0]    nwords_q, nwords_d;
  logic [8:0]    word_cnt_q, word_cnt_d;
  logic [8:0]    wr_cnt_q, wr_cnt_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [31:0]   shift_q, shift_d;
  logic          pend_q, pend_d;
  logic [31:0]   addr_q, addr_d;
  logic          wr_q, wr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          working_q, working_d;
  logic [RW-1:0] run_cnt_q, run_cnt_d;
  logic [3:0]    rid_q, rid_d;
  logic          wait_q, wait_d;
  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
  logic          take;

  assign in_ready  = reset_n & ((state_q == S_IDLE) |
                                ((state_q == S_LOAD) & (word_cnt_q != nwords_q)));
  assign take      = in_valid & in_ready;
  assign busy      = (state_q != S_IDLE);
  assign addr      = addr_q;
  assign wr        = wr_q;
  assign wdata     = wdata_q;
  assign working   = working_q;
  assign rID       = rid_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

  always_comb begin
    state_d     = state_q;
    nwords_d    = nwords_q;
    word_cnt_d  = word_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    pend_d      = 1'b0;
    addr_d      = addr_q;
    wr_d        = 1'b0;
    wdata_d     = wdata_q;
    working_d   = working_q;
    run_cnt_d   = run_cnt_q;
    rid_d       = rid_q;
    wait_d      = wait_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    case (state_q)
      S_IDLE: begin
        if (take) begin
          nwords_d   = ((in_data == '0) || ({1'b0, in_data} > MAXW)) ? MAXW : {1'b0, in_data};
          word_cnt_d = '0;
          wr_cnt_d   = '0;
          byte_cnt_d = '0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (take) begin
          shift_d    = {shift_q[23:0], in_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            word_cnt_d = word_cnt_q + 9'd1;
            pend_d     = 1'b1;
          end
        end
        // shift_q still holds the finished word this cycle even if a new byte shifts in
        if (pend_q) begin
          wr_d     = 1'b1;
          addr_d   = 32'(wr_cnt_q);
          wdata_d  = shift_q;
          wr_cnt_d = wr_cnt_q + 9'd1;
        end
        if (wr_q && (wr_cnt_q == nwords_q)) begin
          working_d = 1'b1;
          run_cnt_d = '0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        run_cnt_d = run_cnt_q + 1'b1;
        if (run_cnt_q == RUN_LAST) begin
          working_d = 1'b0;
          rid_d     = '0;
          wait_d    = 1'b0;
          state_d   = S_DWAIT;
        end
      end
      S_DWAIT: begin
        wait_d = 1'b1;
        if (wait_q) begin
          out_data_d  = rdata;
          out_valid_d = 1'b1;
          out_last_d  = (rid_q == LAST_REG);
          state_d     = S_DOUT;
        end
      end
      S_DOUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (rid_q == LAST_REG) begin
            rid_d   = '1;
            state_d = S_IDLE;
          end else begin
            rid_d   = rid_q + 4'd1;
            wait_d  = 1'b0;
            state_d = S_DWAIT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      nwords_q    <= '0;
      word_cnt_q  <= '0;
      wr_cnt_q    <= '0;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      pend_q      <= 1'b0;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      working_q   <= 1'b0;
      run_cnt_q   <= '0;
      rid_q       <= '1;
      wait_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      nwords_q    <= nwords_d;
      word_cnt_q  <= word_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      pend_q      <= pend_d;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      working_q   <= working_d;
      run_cnt_q   <= run_cnt_d;
      rid_q       <= rid_d;
      wait_q      <= wait_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Bench for prog_loader_ctrl: random byte streams checked against a word/timing model,
// plus a second instance with a short run window.
`timescale 1ns/1ps
module tb_prog_loader_ctrl;

  localparam int unsigned WORDS = 32;
  localparam int unsigned RUN   = 155;
  localparam int unsigned NREGS = 8;
  localparam int unsigned RUN4  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, in_ready, wr, working, out_valid, out_last, busy;
  logic        out_ready = 1'b0;
  logic [7:0]  in_data = '0;
  logic [31:0] addr, wdata, rdata, out_data;
  logic [3:0]  rID;

  logic        in_valid2 = 1'b0, in_ready2, wr2, working2, out_valid2, out_last2, busy2;
  logic        out_ready2 = 1'b0;
  logic [7:0]  in_data2 = '0;
  logic [31:0] addr2, wdata2, rdata2, out_data2;
  logic [3:0]  rID2;

  assign rdata  = 32'h100 + {28'h0, rID};
  assign rdata2 = 32'h100 + {28'h0, rID2};

  prog_loader_ctrl #(.WORDS(WORDS), .RUN_CYCLES(RUN), .NREGS(NREGS)) dut (
    .clock(clk), .reset_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .addr(addr), .wr(wr), .wdata(wdata), .working(working), .rID(rID), .rdata(rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy));

  prog_loader_ctrl #(.WORDS(WORDS), .RUN_CYCLES(RUN4), .NREGS(NREGS)) dut4 (
    .clock(clk), .reset_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .addr(addr2), .wr(wr2), .wdata(wdata2), .working(working2), .rID(rID2), .rdata(rdata2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_last(out_last2),
    .busy(busy2));

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Event monitor: edge numbers of accepted bytes and write pulses, run window extent
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned acc_cyc[$];
  logic [7:0]  acc_byte[$];
  int unsigned wr_cyc[$];
  logic [31:0] wr_addr[$], wr_data[$];
  int unsigned wr_long = 0, work_hi = 0, work_rise = 0, work_fall = 0;
  bit          rise_seen = 0, fall_seen = 0;
  logic        wr_prev = 1'b0, work_prev = 1'b0;

  always @(negedge clk) begin
    if (in_valid && in_ready) begin
      acc_cyc.push_back(cyc + 1);
      acc_byte.push_back(in_data);
    end
    if (wr) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(addr);
      wr_data.push_back(wdata);
    end
    if (wr && wr_prev) wr_long++;
    if (working) work_hi++;
    if (working && !work_prev && !rise_seen) begin rise_seen = 1; work_rise = cyc; end
    if (!working && work_prev && !fall_seen) begin fall_seen = 1; work_fall = cyc; end
    wr_prev   = wr;
    work_prev = working;
  end

  task automatic clear_mon();
    acc_cyc.delete(); acc_byte.delete();
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
    wr_long = 0; work_hi = 0; work_rise = 0; work_fall = 0;
    rise_seen = 0; fall_seen = 0; wr_prev = 1'b0; work_prev = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int unsigned n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_byte: in_ready=%b required 1 within 400 cycles", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic dump_check();
    int unsigned t;
    bit done;
    for (int unsigned b = 0; b < NREGS; b++) begin
      t = 0;
      while (out_valid !== 1'b1 && t < 20) begin
        @(posedge clk); #1; out_ready = 1'($urandom_range(0, 1)); @(negedge clk); t++;
      end
      n_checks++;
      if (out_valid !== 1'b1 || t != 2) begin
        n_fail++;
        $display("FAIL dump_latency beat %0d: out_valid=%b after %0d cycles, required 1 after 2", b, out_valid, t);
      end
      done = 0; t = 0;
      while (!done && t < 100) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h100 + b || out_last !== (b == NREGS - 1) || rID !== 4'(b)) begin
          n_fail++;
          $display("FAIL dump_beat %0d: valid=%b data=%h last=%b rID=%h, required 1 %h %b %h",
                   b, out_valid, out_data, out_last, rID, 32'h100 + b, (b == NREGS - 1), 4'(b));
        end
        if (out_ready) done = 1;
        @(posedge clk); #1; out_ready = 1'($urandom_range(0, 1)); @(negedge clk); t++;
      end
      n_checks++;
      if (!done || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL dump_handshake beat %0d: done=%0d out_valid=%b, required 1 and 0", b, done, out_valid);
      end
    end
    n_checks++;
    if (rID !== 4'hF || busy !== 1'b0 || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL dump_end: rID=%h busy=%b out_last=%b, required f 0 0", rID, busy, out_last);
    end
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic run_stream(input logic [7:0] hdr, input logic [7:0] bytes[$], input bit gaps, input bit hold);
    int unsigned n, t;
    logic [31:0] exp_w;
    bit bad;
    n = (hdr == 0 || hdr > WORDS) ? WORDS : int'(hdr);
    clear_mon();
    send_byte(hdr);
    foreach (bytes[i]) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_byte(bytes[i]);
    end
    if (hold) begin in_valid = 1'b1; in_data = 8'hAA; end
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL in_ready_after_last: in_ready=%b required 0", in_ready);
    end
    t = 0;
    while (working !== 1'b1 && t < 300) begin @(negedge clk); t++; end
    n_checks++;
    if (working !== 1'b1 || rID !== 4'hF) begin
      n_fail++;
      $display("FAIL run_start: working=%b rID=%h, required 1 f", working, rID);
    end
    t = 0;
    while (working === 1'b1 && t < RUN + 20) begin @(negedge clk); t++; end
    in_valid = 1'b0;
    n_checks++;
    if (working !== 1'b0 || rID !== 4'h0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL run_end: working=%b rID=%h busy=%b, required 0 0 1", working, rID, busy);
    end
    dump_check();

    n_checks++;
    if (wr_cyc.size() != n) begin
      n_fail++;
      $display("FAIL write_count: %0d writes, required %0d", wr_cyc.size(), n);
    end else begin
      for (int unsigned w = 0; w < n; w++) begin
        exp_w = {bytes[4*w], bytes[4*w+1], bytes[4*w+2], bytes[4*w+3]};
        n_checks++;
        if (wr_addr[w] !== 32'(w) || wr_data[w] !== exp_w || wr_cyc[w] != acc_cyc[4*w+4] + 1) begin
          n_fail++;
          $display("FAIL write %0d: addr=%h data=%h edge=%0d, required %h %h %0d",
                   w, wr_addr[w], wr_data[w], wr_cyc[w], 32'(w), exp_w, acc_cyc[4*w+4] + 1);
        end
      end
      n_checks++;
      if (work_rise != wr_cyc[n-1] + 1) begin
        n_fail++;
        $display("FAIL run_handoff: working rose at edge %0d, required %0d", work_rise, wr_cyc[n-1] + 1);
      end
    end
    n_checks++;
    if (wr_long != 0) begin
      n_fail++;
      $display("FAIL wr_pulse_width: %0d multi-cycle pulses, required 0", wr_long);
    end
    n_checks++;
    if (work_hi != RUN || work_fall - work_rise != RUN) begin
      n_fail++;
      $display("FAIL run_window: high %0d cycles, span %0d, required %0d", work_hi, work_fall - work_rise, RUN);
    end
    bad = (acc_byte.size() != 4 * n + 1) || (acc_byte.size() > 0 && acc_byte[0] !== hdr);
    for (int unsigned i = 1; i < acc_byte.size() && i <= 4 * n; i++)
      if (acc_byte[i] !== bytes[i-1]) bad = 1;
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL accepted_bytes: %0d accepted, required %0d in stream order", acc_byte.size(), 4 * n + 1);
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || rID !== 4'hF || wr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b busy=%b rID=%h wr=%b, required 1 0 f 0", in_ready, busy, rID, wr);
    end
    send_byte(8'h03);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    @(posedge clk); #1;
    n_checks++;
    if (wr !== 1'b1 || wdata !== 32'hDEADBEEF || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_write: wr=%b wdata=%h busy=%b, required 1 deadbeef 1", wr, wdata, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (addr !== '0 || wr !== 1'b0 || wdata !== '0 || working !== 1'b0 || rID !== 4'hF || in_ready !== 1'b0 ||
        out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: addr=%h wr=%b wdata=%h working=%b rID=%h in_ready=%b ov=%b od=%h ol=%b busy=%b",
               addr, wr, wdata, working, rID, in_ready, out_valid, out_data, out_last, busy);
    end
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0 || in_ready2 !== 1'b0) begin
      n_fail++;
      $display("FAIL in_ready_in_reset: in_ready=%b in_ready2=%b, required 0 0", in_ready, in_ready2);
    end
    #2 rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL in_ready_after_release: in_ready=%b busy=%b, required 1 0", in_ready, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load();
    logic [7:0] q[$];
    q = '{8'h10, 8'hF0, 8'h00, 8'h01, 8'h70, 8'h00, 8'h00, 8'h0A};
    run_stream(8'h02, q, 1'b0, 1'b1);
  endtask

  task automatic test_header_clamp();
    logic [7:0] q[$];
    for (int unsigned i = 0; i < 4 * WORDS; i++) q.push_back(8'($urandom));
    run_stream(8'h00, q, 1'b0, 1'b0);
    q.delete();
    for (int unsigned i = 0; i < 4 * WORDS; i++) q.push_back(8'($urandom));
    run_stream(8'd40, q, 1'b0, 1'b1);
  endtask

  task automatic test_random_streams();
    logic [7:0] q[$];
    int unsigned n;
    for (int unsigned k = 0; k < 3; k++) begin
      n = $urandom_range(1, WORDS);
      q.delete();
      for (int unsigned i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
      run_stream(8'(n), q, 1'b1, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_during_load();
    logic [7:0] q[$];
    clear_mon();
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (wr_cyc.size() != 0) begin
      n_fail++;
      $display("FAIL reset_in_load_no_write: %0d writes, required 0", wr_cyc.size());
    end
    @(posedge clk); #1;
    q = '{8'h20, 8'h76, 8'h00, 8'h00};
    run_stream(8'h01, q, 1'b0, 1'b0);
  endtask

  task automatic test_run_short();
    logic [7:0] q[$];
    int unsigned t, cnt, beats;
    bit wr_ok;
    q = '{8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
    wr_ok = 0;
    foreach (q[i]) begin
      in_valid2 = 1'b1; in_data2 = q[i];
      t = 0;
      @(negedge clk);
      while (in_ready2 !== 1'b1 && t < 50) begin @(negedge clk); t++; end
      @(posedge clk); #1;
    end
    in_data2 = 8'hAA;
    t = 0;
    @(negedge clk);
    while (working2 !== 1'b1 && t < 50) begin
      if (wr2 === 1'b1 && addr2 === 32'h0 && wdata2 === 32'h12345678) wr_ok = 1;
      @(negedge clk); t++;
    end
    n_checks++;
    if (!wr_ok) begin
      n_fail++;
      $display("FAIL short_write: write of 12345678 at addr 0 seen=%0d, required 1", wr_ok);
    end
    cnt = 0;
    while (working2 === 1'b1 && cnt < 50) begin cnt++; @(negedge clk); end
    in_valid2 = 1'b0;
    n_checks++;
    if (cnt != RUN4 || rID2 !== 4'h0) begin
      n_fail++;
      $display("FAIL short_run_window: working high %0d cycles rID=%h, required %0d 0", cnt, rID2, RUN4);
    end
    out_ready2 = 1'b1;
    t = 0; beats = 0;
    while (busy2 === 1'b1 && t < 100) begin
      if (out_valid2 === 1'b1) begin
        n_checks++;
        if (out_data2 !== 32'h100 + beats || out_last2 !== (beats == NREGS - 1)) begin
          n_fail++;
          $display("FAIL short_dump beat %0d: data=%h last=%b, required %h %b",
                   beats, out_data2, out_last2, 32'h100 + beats, (beats == NREGS - 1));
        end
        beats++;
      end
      @(negedge clk); t++;
    end
    n_checks++;
    if (t != 3 * NREGS || beats != NREGS || rID2 !== 4'hF) begin
      n_fail++;
      $display("FAIL short_dump_rate: %0d cycles %0d beats rID=%h, required %0d %0d f", t, beats, rID2, 3 * NREGS, NREGS);
    end
    out_ready2 = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    test_reset();
    test_load();
    test_header_clamp();
    test_random_streams();
    test_reset_during_load();
    test_run_short();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded 1 ms, required completion");
    $fatal(1, "watchdog");
  end

endmodule
